// File: rtl/regfile_port_sched_if.sv
// Bundle of requester, debug and register-file signals around the port scheduler.
// The slave modport is the scheduler; master is the surrounding pipeline plus the file.
interface regfile_port_sched_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_rd;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 stall;
  logic                 dbg_req;
  logic [3:0]           dbg_rd;
  logic [7:0]           dbg_data;
  logic                 dbg_done;
  logic [3:0]           rf_rd;
  logic [7:0]           rf_wdata;
  logic                 rf_we;
  logic                 rf_oe;
  logic [7:0]           rf_rdata;
  logic [7:0]           contention_cnt;

  modport master (
    output req_valid, req_rd, req_data, stall, dbg_req, dbg_rd, rf_rdata,
    input  req_ready, dbg_data, dbg_done, rf_rd, rf_wdata, rf_we, rf_oe, contention_cnt
  );

  modport slave (
    input  req_valid, req_rd, req_data, stall, dbg_req, dbg_rd, rf_rdata,
    output req_ready, dbg_data, dbg_done, rf_rd, rf_wdata, rf_we, rf_oe, contention_cnt
  );
endinterface

// File: rtl/regfile_port_sched.sv
// Round-robin write arbiter plus multi-cycle debug read sequencer for the
// single rd-addressed port of the 16x8 register file. All file strobes are registered.
module regfile_port_sched #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned STARVE_LIM = 8
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  regfile_port_sched_if.slave  bus
);

  localparam int unsigned PtrW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {StIdle, StRdIssue, StRdCapture} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;
  logic [3:0]        starve_q;
  logic [7:0]        contention_q;
  logic [3:0]        rf_rd_q;
  logic [7:0]        rf_wdata_q;
  logic              rf_we_q;
  logic              rf_oe_q;
  logic [7:0]        dbg_data_q;
  logic              dbg_done_q;

  logic              grantable;
  logic              dbg_win;
  logic              wr_win;
  logic              contend;
  logic              win_found;
  logic [PtrW-1:0]   win_idx;
  logic [PtrW-1:0]   win_next;
  logic [3:0]        win_rd;
  logic [7:0]        win_data;
  logic [PtrW:0]     cand_sum;
  logic [PtrW-1:0]   cand;
  logic [NUM_REQ-1:0] ready;

  // Reset gates grantability so req_ready stays low while rst_ni is asserted.
  assign grantable = rst_ni && (state_q == StIdle) && !bus.stall;
  assign dbg_win   = grantable && bus.dbg_req &&
                     ((bus.req_valid == '0) || (starve_q == 4'(STARVE_LIM)));
  assign wr_win    = grantable && !dbg_win && win_found;
  assign contend   = grantable && ($countones(bus.req_valid) >= 2);

  // Find the first valid requester scanning upward from ptr_q with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_next  = '0;
    win_rd    = '0;
    win_data  = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (cand_sum >= (PtrW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (PtrW+1)'(NUM_REQ);
      end
      cand = cand_sum[PtrW-1:0];
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_rd    = bus.req_rd[{cand, 2'b00} +: 4];
        win_data  = bus.req_data[{cand, 3'b000} +: 8];
        win_next  = (cand == PtrW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      end
    end
  end

  // One-hot ready for the write winner, combinational in the grant cycle.
  always_comb begin
    ready = '0;
    if (wr_win) begin
      ready[win_idx] = 1'b1;
    end
  end

  // Main FSM; every file-side output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      starve_q     <= '0;
      contention_q <= '0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
      rf_we_q      <= 1'b0;
      rf_oe_q      <= 1'b0;
      dbg_data_q   <= '0;
      dbg_done_q   <= 1'b0;
    end else begin
      dbg_done_q <= 1'b0;
      if (contend && (contention_q != 8'hFF)) begin
        contention_q <= contention_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (dbg_win) begin
            rf_rd_q  <= bus.dbg_rd;
            rf_we_q  <= 1'b0;
            rf_oe_q  <= 1'b1;
            starve_q <= '0;
            state_q  <= StRdIssue;
          end else if (wr_win) begin
            rf_rd_q    <= win_rd;
            rf_wdata_q <= win_data;
            rf_we_q    <= 1'b1;
            rf_oe_q    <= 1'b0;
            ptr_q      <= win_next;
            // A pending debug read lost this cycle to a writer.
            if (bus.dbg_req && (starve_q != 4'(STARVE_LIM))) begin
              starve_q <= starve_q + 4'd1;
            end
          end else begin
            rf_we_q <= 1'b0;
            rf_oe_q <= 1'b0;
          end
        end
        StRdIssue: begin
          rf_oe_q <= 1'b0;
          rf_we_q <= 1'b0;
          state_q <= StRdCapture;
        end
        StRdCapture: begin
          dbg_data_q <= bus.rf_rdata;
          dbg_done_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready      = ready;
  assign bus.rf_rd          = rf_rd_q;
  assign bus.rf_wdata       = rf_wdata_q;
  assign bus.rf_we          = rf_we_q;
  assign bus.rf_oe          = rf_oe_q;
  assign bus.dbg_data       = dbg_data_q;
  assign bus.dbg_done       = dbg_done_q;
  assign bus.contention_cnt = contention_q;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Bench for regfile_port_sched: directed scenarios plus random traffic, all checked
// against a transaction-level reference model and a behavioural 16x8 register file.
module tb_regfile_port_sched;

  localparam int unsigned NR  = 3;
  localparam int unsigned LIM = 8;

  logic clk;
  logic rst_n;

  regfile_port_sched_if #(.NUM_REQ(NR)) bus ();

  regfile_port_sched #(
    .NUM_REQ    (NR),
    .STARVE_LIM (LIM)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: write on rf_we, refresh data_out on rf_oe.
  logic [7:0] rf_mem [16];
  always @(posedge clk) begin
    if (bus.rf_we) rf_mem[bus.rf_rd] <= bus.rf_wdata;
    if (bus.rf_oe) bus.rf_rdata <= rf_mem[bus.rf_rd];
  end

  int n_checks;
  int n_fail;

  // Reference model state.
  int m_phase;   // 0 idle, 1 read issued, 2 read capturing
  int m_ptr, m_starve, m_cnt;
  int m_rd, m_wdata, m_we, m_oe, m_dbg_data, m_done, m_pend;
  int m_mem [16];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_starve = 0; m_cnt = 0;
    m_rd = 0; m_wdata = 0; m_we = 0; m_oe = 0; m_dbg_data = 0; m_done = 0; m_pend = 0;
  endtask

  // One clock cycle: drive, check req_ready, take the edge, check registered outputs.
  task automatic step(input logic [NR-1:0] v, input logic [4*NR-1:0] rd,
                      input logic [8*NR-1:0] d, input logic st, input logic dq,
                      input logic [3:0] drd, output int obs_ready);
    int vi, rdi, di, win, exp_ready, pc;
    bit gd;
    bus.req_valid = v;
    bus.req_rd    = rd;
    bus.req_data  = d;
    bus.stall     = st;
    bus.dbg_req   = dq;
    bus.dbg_rd    = drd;
    #1;
    vi  = 32'(v);
    rdi = 32'(rd);
    di  = 32'(d);
    pc  = $countones(v);
    gd  = 1'b0;
    win = -1;
    if (m_phase == 0 && !st) begin
      if (dq && (vi == 0 || m_starve == LIM)) gd = 1'b1;
      else begin
        for (int k = 0; k < NR; k++) begin
          int idx;
          idx = (m_ptr + k) % NR;
          if (win < 0 && ((vi >> idx) & 1) != 0) win = idx;
        end
      end
    end
    exp_ready = (win >= 0) ? (1 << win) : 0;
    obs_ready = 32'(bus.req_ready);
    check("req_ready", obs_ready, exp_ready);
    @(posedge clk);
    m_done = 0;
    if (m_phase == 0) begin
      if (!st && pc >= 2 && m_cnt < 255) m_cnt++;
      if (gd) begin
        m_rd = 32'(drd); m_we = 0; m_oe = 1; m_starve = 0; m_phase = 1;
        m_pend = m_mem[m_rd];
      end else if (win >= 0) begin
        m_rd    = (rdi >> (4 * win)) & 15;
        m_wdata = (di >> (8 * win)) & 255;
        m_we = 1; m_oe = 0;
        m_ptr = (win + 1) % NR;
        m_mem[m_rd] = m_wdata;
        if (dq && m_starve < LIM) m_starve++;
      end else begin
        m_we = 0; m_oe = 0;
      end
    end else if (m_phase == 1) begin
      m_oe = 0; m_phase = 2;
    end else begin
      m_dbg_data = m_pend; m_done = 1; m_phase = 0;
    end
    #1;
    check("rf_rd", 32'(bus.rf_rd), m_rd);
    check("rf_wdata", 32'(bus.rf_wdata), m_wdata);
    check("rf_we", 32'(bus.rf_we), m_we);
    check("rf_oe", 32'(bus.rf_oe), m_oe);
    check("dbg_done", 32'(bus.dbg_done), m_done);
    check("dbg_data", 32'(bus.dbg_data), m_dbg_data);
    check("contention_cnt", 32'(bus.contention_cnt), m_cnt);
  endtask

  task automatic drive_idle();
    bus.req_valid = '0; bus.req_rd = '0; bus.req_data = '0;
    bus.stall = 1'b0; bus.dbg_req = 1'b0; bus.dbg_rd = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_rd"}, 32'(bus.rf_rd), 0);
    check({tag, "_rf_wdata"}, 32'(bus.rf_wdata), 0);
    check({tag, "_rf_we"}, 32'(bus.rf_we), 0);
    check({tag, "_rf_oe"}, 32'(bus.rf_oe), 0);
    check({tag, "_dbg_data"}, 32'(bus.dbg_data), 0);
    check({tag, "_dbg_done"}, 32'(bus.dbg_done), 0);
    check({tag, "_cnt"}, 32'(bus.contention_cnt), 0);
  endtask

  // Assert reset, check outputs while held, release, and realign to posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    bus.req_valid = '1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int rdy, writes;
    logic [NR-1:0]   v;
    logic [4*NR-1:0] rd;
    logic [8*NR-1:0] d;
    logic            st, dq;
    logic [3:0]      drd;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 8'h00;
      m_mem[i]  = 0;
    end
    bus.rf_rdata = 8'h00;
    do_reset();

    // Single write from requester 0.
    step(3'b001, 12'h005, 24'h0000A7, 1'b0, 1'b0, 4'd0, rdy);
    check("single_ready", rdy, 1);
    check("single_we", 32'(bus.rf_we), 1);
    check("single_rd", 32'(bus.rf_rd), 5);
    check("single_wdata", 32'(bus.rf_wdata), 'hA7);
    step(3'b000, 12'h000, 24'h000000, 1'b0, 1'b0, 4'd0, rdy);
    check("single_we_drop", 32'(bus.rf_we), 0);

    // Round robin with all requesters held.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 12'h321, 24'h332211, 1'b0, 1'b0, 4'd0, rdy);
      check("rr_order", rdy, 1 << (i % 3));
      check("rr_we", 32'(bus.rf_we), 1);
    end
    check("rr_contention", 32'(bus.contention_cnt), 6);

    // Stall blocks grants; ptr is unchanged (back at 0 after six grants).
    for (int i = 0; i < 3; i++) begin
      step(3'b010, 12'h070, 24'h00EE00, 1'b1, 1'b0, 4'd0, rdy);
      check("stall_ready", rdy, 0);
      check("stall_we", 32'(bus.rf_we), 0);
    end
    step(3'b010, 12'h070, 24'h00EE00, 1'b0, 1'b0, 4'd0, rdy);
    check("post_stall_ready", rdy, 2);
    step(3'b111, 12'h321, 24'h332211, 1'b0, 1'b0, 4'd0, rdy);
    check("post_stall_ptr", rdy, 4);

    // Debug read of a freshly written register.
    step(3'b001, 12'h009, 24'h00003C, 1'b0, 1'b0, 4'd0, rdy);
    step(3'b000, 12'h000, 24'h000000, 1'b0, 1'b1, 4'd9, rdy);
    check("dbg_oe", 32'(bus.rf_oe), 1);
    check("dbg_oe_rd", 32'(bus.rf_rd), 9);
    step(3'b000, 12'h000, 24'h000000, 1'b0, 1'b1, 4'd9, rdy);
    check("dbg_oe_pulse", 32'(bus.rf_oe), 0);
    step(3'b000, 12'h000, 24'h000000, 1'b0, 1'b1, 4'd9, rdy);
    check("dbg_done_pulse", 32'(bus.dbg_done), 1);
    check("dbg_value", 32'(bus.dbg_data), 'h3C);
    step(3'b000, 12'h000, 24'h000000, 1'b0, 1'b0, 4'd0, rdy);
    check("dbg_done_single", 32'(bus.dbg_done), 0);

    // Starvation: one writer held, debug read forced after LIM lost cycles.
    do_reset();
    writes = 0;
    for (int i = 0; i < 20; i++) begin
      step(3'b001, 12'h004, 24'h000055, 1'b0, 1'b1, 4'd4, rdy);
      if (rdy == 0) break;
      writes++;
    end
    check("starve_writes", writes, LIM);
    check("starve_forced_oe", 32'(bus.rf_oe), 1);
    for (int i = 0; i < 2; i++) begin
      step(3'b001, 12'h004, 24'h000055, 1'b0, 1'b1, 4'd4, rdy);
      check("starve_blocked", rdy, 0);
    end
    check("starve_dbg_data", 32'(bus.dbg_data), 'h55);
    step(3'b001, 12'h004, 24'h000056, 1'b0, 1'b0, 4'd0, rdy);
    check("starve_resume", rdy, 1);

    // Asynchronous reset while the read is in RD_ISSUE.
    step(3'b000, 12'h000, 24'h000000, 1'b0, 1'b1, 4'd4, rdy);
    check("mid_rst_pre_oe", 32'(bus.rf_oe), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(bus.rf_oe), 0);
    check("mid_rst_rd", 32'(bus.rf_rd), 0);
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_done", 32'(bus.dbg_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 12'h000, 24'h000000, 1'b0, 1'b0, 4'd0, rdy);
    end
    step(3'b111, 12'hABC, 24'h123456, 1'b0, 1'b0, 4'd0, rdy);
    check("post_rst_ptr0", rdy, 1);

    // Random traffic with a well-behaved debug requester.
    dq  = 1'b0;
    drd = 4'd0;
    for (int i = 0; i < 400; i++) begin
      v  = NR'($urandom_range(0, 7));
      rd = 12'($urandom);
      d  = 24'($urandom);
      st = ($urandom_range(0, 4) == 0);
      if (bus.dbg_done) dq = 1'b0;
      else if (!dq && $urandom_range(0, 7) == 0) begin
        dq  = 1'b1;
        drd = 4'($urandom);
      end
      step(v, rd, d, st, dq, drd, rdy);
      check("we_oe_exclusive", 32'(bus.rf_we & bus.rf_oe), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
